// File: rtl/serial_adder_pkg.sv
// Shared state encoding and default width for the bit-serial adder.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/serial_adder_full_adder.sv
// Combinational adder cells: half_adder and a full_adder built from two of them.
module half_adder (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b;
    assign cout = a & b;

endmodule

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic s0;
    logic c0;
    logic c1;

    half_adder u_ha0 (
        .a    (a),
        .b    (b),
        .sum  (s0),
        .cout (c0)
    );

    half_adder u_ha1 (
        .a    (s0),
        .b    (cin),
        .sum  (sum),
        .cout (c1)
    );

    assign cout = c0 | c1;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder with start/busy/done handshake.
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             fa_sum;
    logic             fa_cout;
    logic             accept;

    full_adder u_fa (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    assign accept = start && (state_q != ST_RUN);

`ifdef SERIAL_ADDER_OVF_EN
    logic ovf_q, ovf_d;
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_RUN;
            end
            ST_RUN: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                sum_d   = {fa_sum, sum_q[WIDTH-1:1]};
                carry_d = fa_cout;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                    cout_d  = fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
                    // carry_q is the carry into the MSB on the final bit
                    ovf_d   = carry_q ^ fa_cout;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = accept ? ST_RUN : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (accept) begin
            a_d     = a;
            b_d     = b;
            carry_d = cin;
            cnt_d   = '0;
            sum_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ovf_q <= 1'b0;
        else     ovf_q <= ovf_d;
    end

    assign ovf = ovf_q;
`endif

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: directed and random additions.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    typedef struct packed {
        logic [W:0] res;
        logic       ovf;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(input logic [W-1:0] x,
                                   input logic [W-1:0] y,
                                   input logic c);
        exp_t   e;
        longint u;
        longint s;
        u = longint'(x) + longint'(y) + longint'(c);
        s = longint'($signed(x)) + longint'($signed(y)) + longint'(c);
        e.res = u[W:0];
        e.ovf = (s > (2 ** (W - 1)) - 1) || (s < -(2 ** (W - 1)));
        return e;
    endfunction

    task automatic check(input string name, input longint act,
                         input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse consumes one scoreboard entry.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && done) begin
            if (q.size() == 0) begin
                check("spurious_done", done, 0);
            end else begin
                e = q.pop_front();
                check("sum", sum, e.res[W-1:0]);
                check("cout", cout, e.res[W]);
`ifdef SERIAL_ADDER_OVF_EN
                check("ovf", ovf, e.ovf);
`endif
                check("busy_at_done", busy, 0);
            end
        end
    end

    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic ic, input bit push);
        start = 1'b1;
        a     = ia;
        b     = ib;
        cin   = ic;
        if (push) q.push_back(model(ia, ib, ic));
        @(negedge clk);
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        cin   = 1'($urandom);
    endtask

    // Runs one op; optionally pulses a junk start at RUN cycle inj.
    task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                          input logic ic, input int inj);
        int n;
        int nbusy;
        issue(ia, ib, ic, 1'b1);
        n     = 1;
        nbusy = busy ? 1 : 0;
        while (!done && n < 40) begin
            start = (n == inj);
            if (n == inj) begin
                a = '1;
                b = '1;
            end
            @(negedge clk);
            n++;
            if (busy) nbusy++;
        end
        start = 1'b0;
        check("latency", n, W + 1);
        check("busy_cycles", nbusy, W);
    endtask

    task automatic wait_done(output int t);
        int n;
        n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", done, 1);
        t = cyc;
    endtask

    initial begin
        int t1;
        int t2;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
`ifdef SERIAL_ADDER_OVF_EN
        check("rst_ovf", ovf, 0);
`endif
        rst = 1'b0;
        @(negedge clk);

        run_op(8'h00, 8'h00, 1'b0, 0);
        run_op(8'hFF, 8'h01, 1'b0, 0);
        run_op(8'h7F, 8'h01, 1'b0, 0);
        run_op(8'h35, 8'h4A, 1'b1, 0);
        run_op(8'h80, 8'h80, 1'b0, 0);
        run_op(8'hFF, 8'hFF, 1'b1, 0);
        run_op(8'h10, 8'h20, 1'b0, 3);
        @(negedge clk);

        // Abort mid-run: outputs clear at once, no done follows.
        issue(8'hAA, 8'h55, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_sum", sum, 0);
        check("abort_cout", cout, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        run_op(8'h12, 8'h34, 1'b0, 0);
        @(negedge clk);

        // Back-to-back with start held through DONE.
        start = 1'b1;
        a     = 8'h01;
        b     = 8'h02;
        cin   = 1'b0;
        q.push_back(model(8'h01, 8'h02, 1'b0));
        @(negedge clk);
        a = 8'h03;
        b = 8'h04;
        q.push_back(model(8'h03, 8'h04, 1'b0));
        wait_done(t1);
        @(negedge clk);
        start = 1'b0;
        check("b2b_busy", busy, 1);
        wait_done(t2);
        check("b2b_gap", t2 - t1, W + 1);
        @(negedge clk);

        for (int i = 0; i < 30; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), 0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        check("queue_empty", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
